// File: rtl/mc_dp_regs.sv
// Inter-state register file of the multicycle MIPS datapath: PC, IR, MDR, A, B, ALUOut,
// memory address mux and IR field decode, all driven by the control-unit strobes.
module mc_dp_regs #(
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PCWr,
    input  logic             PCWrCond,
    input  logic             IorD,
    input  logic             IRWr,
    input  logic [1:0]       PCSrc,
    input  logic             Zero,
    input  logic [WIDTH-1:0] ALUResult,
    input  logic [WIDTH-1:0] MemData,
    input  logic [WIDTH-1:0] RegRdA,
    input  logic [WIDTH-1:0] RegRdB,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] MemAddr,
    output logic [WIDTH-1:0] IR,
    output logic [WIDTH-1:0] MDR,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALUOut,
    output logic [5:0]       Op,
    output logic [4:0]       Rs,
    output logic [4:0]       Rt,
    output logic [4:0]       Rd,
    output logic [WIDTH-1:0] ImmSE,
    output logic [WIDTH-1:0] ImmSL2,
    output logic             AddrErr
);

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_ALUO = 2'b01;
    localparam logic [1:0] SRC_JMP  = 2'b10;

    function automatic logic [WIDTH-1:0] sext16(input logic [15:0] v);
        return {{(WIDTH-16){v[15]}}, v};
    endfunction

    function automatic logic [WIDTH-1:0] jump_target(input logic [WIDTH-1:0] pc,
                                                     input logic [WIDTH-1:0] ir);
        return {pc[WIDTH-1:WIDTH-4], ir[25:0], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [WIDTH-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    function automatic logic [WIDTH-1:0] word_align(input logic [WIDTH-1:0] addr);
        return {addr[WIDTH-1:2], 2'b00};
    endfunction

    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] ir_r;
    logic [WIDTH-1:0] mdr_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] aluout_r;
    logic             addr_err_r;

    logic             pcen_s;
    logic             src_valid_s;
    logic [WIDTH-1:0] target_s;
    logic             pc_load_s;
    logic             misalign_s;
    logic [WIDTH-1:0] imm_se_s;

    // Next-PC source select; the reserved encoding suppresses the write entirely.
    always_comb begin
        target_s    = pc_r;
        src_valid_s = 1'b0;
        case (PCSrc)
            SRC_ALU: begin
                target_s    = ALUResult;
                src_valid_s = 1'b1;
            end
            SRC_ALUO: begin
                target_s    = aluout_r;
                src_valid_s = 1'b1;
            end
            SRC_JMP: begin
                target_s    = jump_target(pc_r, ir_r);
                src_valid_s = 1'b1;
            end
            default: begin
                target_s    = pc_r;
                src_valid_s = 1'b0;
            end
        endcase
    end

    // Write enable is an OR of the two strobes, not a priority between them.
    always_comb begin
        pcen_s     = PCWr | (PCWrCond & Zero);
        pc_load_s  = pcen_s & src_valid_s;
        misalign_s = pc_load_s & is_misaligned(target_s);
    end

    // Program counter and sticky misalignment flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_r       <= RESET_PC;
            addr_err_r <= 1'b0;
        end else begin
            if (pc_load_s) begin
                pc_r <= word_align(target_s);
            end else begin
                pc_r <= pc_r;
            end
            if (misalign_s) begin
                addr_err_r <= 1'b1;
            end else begin
                addr_err_r <= addr_err_r;
            end
        end
    end

    // Instruction register, loaded only on fetch.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ir_r <= {WIDTH{1'b0}};
        end else if (IRWr) begin
            ir_r <= MemData;
        end else begin
            ir_r <= ir_r;
        end
    end

    // Free-running inter-state latches: captured every cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mdr_r    <= {WIDTH{1'b0}};
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            aluout_r <= {WIDTH{1'b0}};
        end else begin
            mdr_r    <= MemData;
            a_r      <= RegRdA;
            b_r      <= RegRdB;
            aluout_r <= ALUResult;
        end
    end

    // Instruction field decode; the shifted offset wraps to 32 bits.
    always_comb begin
        imm_se_s = sext16(ir_r[15:0]);
        Op       = ir_r[31:26];
        Rs       = ir_r[25:21];
        Rt       = ir_r[20:16];
        Rd       = ir_r[15:11];
        ImmSE    = imm_se_s;
        ImmSL2   = {imm_se_s[WIDTH-3:0], 2'b00};
    end

    // Memory address uses registered sources only, so it is glitch-free per state.
    always_comb begin
        if (IorD) begin
            MemAddr = aluout_r;
        end else begin
            MemAddr = pc_r;
        end
    end

    assign PC      = pc_r;
    assign IR      = ir_r;
    assign MDR     = mdr_r;
    assign A       = a_r;
    assign B       = b_r;
    assign ALUOut  = aluout_r;
    assign AddrErr = addr_err_r;

endmodule

// File: tb/tb_mc_dp_regs.sv
// Bench for mc_dp_regs: directed scenarios with literal expectations, then random
// strobe traffic, all checked every cycle against an architectural model.
module tb_mc_dp_regs;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        CLK = 1'b0;
    logic        RST, PCWr, PCWrCond, IorD, IRWr, Zero;
    logic [1:0]  PCSrc;
    logic [31:0] ALUResult, MemData, RegRdA, RegRdB;
    logic [31:0] PC, MemAddr, IR, MDR, A, B, ALUOut, ImmSE, ImmSL2;
    logic [5:0]  Op;
    logic [4:0]  Rs, Rt, Rd;
    logic        AddrErr;

    int nvec = 0;
    int nerr = 0;

    // architectural model state
    logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_aluout;
    logic        m_err;

    mc_dp_regs #(.WIDTH(32), .RESET_PC(RPC)) dut (
        .CLK(CLK), .RST(RST), .PCWr(PCWr), .PCWrCond(PCWrCond), .IorD(IorD),
        .IRWr(IRWr), .PCSrc(PCSrc), .Zero(Zero), .ALUResult(ALUResult),
        .MemData(MemData), .RegRdA(RegRdA), .RegRdB(RegRdB), .PC(PC),
        .MemAddr(MemAddr), .IR(IR), .MDR(MDR), .A(A), .B(B), .ALUOut(ALUOut),
        .Op(Op), .Rs(Rs), .Rt(Rt), .Rd(Rd), .ImmSE(ImmSE), .ImmSL2(ImmSL2),
        .AddrErr(AddrErr)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural effect of one clock edge, from the datapath rules.
    task automatic model_edge();
        logic [31:0] tgt;
        logic        ok, pcen;
        if (RST) begin
            m_pc = RPC; m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_aluout = 0; m_err = 0;
        end else begin
            pcen = PCWr || (PCWrCond && Zero);
            ok   = 1'b1;
            tgt  = 0;
            case (PCSrc)
                2'd0: tgt = ALUResult;
                2'd1: tgt = m_aluout;
                2'd2: tgt = (m_pc & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 4);
                default: ok = 1'b0;
            endcase
            if (pcen && ok) begin
                if (tgt % 4 != 0) m_err = 1'b1;
                m_pc = tgt - (tgt % 4);
            end
            if (IRWr) m_ir = MemData;
            m_mdr = MemData; m_a = RegRdA; m_b = RegRdB; m_aluout = ALUResult;
        end
    endtask

    // Compare every output against the model.
    task automatic check_all();
        int imm;
        imm = int'(m_ir & 32'h0000_FFFF);
        if (imm >= 32768) imm = imm - 65536;
        chk("pc", PC, m_pc);
        chk("ir", IR, m_ir);
        chk("mdr", MDR, m_mdr);
        chk("a", A, m_a);
        chk("b", B, m_b);
        chk("aluout", ALUOut, m_aluout);
        chk("addrerr", {31'd0, AddrErr}, {31'd0, m_err});
        chk("memaddr", MemAddr, IorD ? m_aluout : m_pc);
        chk("op", {26'd0, Op}, m_ir >> 26);
        chk("rs", {27'd0, Rs}, (m_ir >> 21) % 32);
        chk("rt", {27'd0, Rt}, (m_ir >> 16) % 32);
        chk("rd", {27'd0, Rd}, (m_ir >> 11) % 32);
        chk("immse", ImmSE, 32'(imm));
        chk("immsl2", ImmSL2, 32'(imm * 4));
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_all();
    endtask

    task automatic idle();
        RST = 0; PCWr = 0; PCWrCond = 0; IorD = 0; IRWr = 0; PCSrc = 2'd0; Zero = 0;
    endtask

    initial begin
        idle();
        ALUResult = 0; MemData = 0; RegRdA = 0; RegRdB = 0;
        m_pc = 0; m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_aluout = 0; m_err = 0;

        // reset held for two edges
        RST = 1;
        cycle(); cycle();
        chk("rst_pc", PC, 32'h0040_0000);
        chk("rst_ir", IR, 32'h0);
        chk("rst_err", {31'd0, AddrErr}, 32'd0);
        chk("rst_memaddr", MemAddr, 32'h0040_0000);

        // fetch of lw
        idle();
        MemData = 32'h8C22_0004; IRWr = 1; PCWr = 1; ALUResult = 32'h0040_0004;
        cycle();
        chk("fetch_ir", IR, 32'h8C22_0004);
        chk("fetch_op", {26'd0, Op}, 32'h23);
        chk("fetch_rs", {27'd0, Rs}, 32'd1);
        chk("fetch_rt", {27'd0, Rt}, 32'd2);
        chk("fetch_immse", ImmSE, 32'd4);
        chk("fetch_immsl2", ImmSL2, 32'h10);
        chk("fetch_pc", PC, 32'h0040_0004);

        // beq: not taken then taken
        idle(); ALUResult = 32'h0040_0020;
        cycle();
        PCWrCond = 1; PCSrc = 2'd1; Zero = 0;
        cycle();
        chk("beq_nt_pc", PC, 32'h0040_0004);
        Zero = 1;
        cycle();
        chk("beq_t_pc", PC, 32'h0040_0020);

        // jump within the current 256MB region
        idle(); PCWr = 1; ALUResult = 32'h1000_0008; IRWr = 1; MemData = 32'h0800_0010;
        cycle();
        chk("j_setup_pc", PC, 32'h1000_0008);
        idle(); PCWr = 1; PCSrc = 2'd2;
        cycle();
        chk("j_pc", PC, 32'h1000_0040);

        // misaligned target, stickiness, reserved select
        idle(); ALUResult = 32'h0040_0006; PCWr = 1;
        cycle();
        chk("mis_pc", PC, 32'h0040_0004);
        chk("mis_err", {31'd0, AddrErr}, 32'd1);
        idle(); ALUResult = 32'h0000_0100;
        cycle(); cycle();
        chk("mis_sticky", {31'd0, AddrErr}, 32'd1);
        PCWr = 1; PCSrc = 2'd3; ALUResult = 32'h0000_0003;
        cycle();
        chk("rsv_pc", PC, 32'h0040_0004);
        chk("rsv_err", {31'd0, AddrErr}, 32'd1);

        // data address, then reset mid-load
        idle(); ALUResult = 32'h1001_0000; RegRdA = 32'hAAAA_5555; RegRdB = 32'h1234_5678;
        cycle();
        IorD = 1;
        cycle();
        chk("iord_memaddr", MemAddr, 32'h1001_0000);
        RST = 1; PCWr = 1; IRWr = 1; MemData = 32'hDEAD_BEEF;
        cycle();
        chk("midrst_pc", PC, 32'h0040_0000);
        chk("midrst_ir", IR, 32'h0);
        chk("midrst_alu", ALUOut, 32'h0);
        chk("midrst_err", {31'd0, AddrErr}, 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            RST       = ($urandom_range(0, 63) == 0);
            PCWr      = ($urandom_range(0, 3) == 0);
            PCWrCond  = ($urandom_range(0, 3) == 0);
            Zero      = $urandom_range(0, 1) != 0;
            IorD      = $urandom_range(0, 1) != 0;
            IRWr      = ($urandom_range(0, 2) == 0);
            PCSrc     = 2'($urandom_range(0, 3));
            ALUResult = $urandom;
            if ($urandom_range(0, 1) == 0) ALUResult[1:0] = 2'b00;
            MemData   = $urandom;
            RegRdA    = $urandom;
            RegRdB    = $urandom;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
